md_sequencer: RTL and testbench

- Execute-stage controller for the HI/LO multiply/divide resource in the pipelined core.
- Accepts the decoded mult/multu/div/divu/mthi/mtlo/mfhi/mflo strobes with operand values and runs multi-cycle mult/div operations for a fixed latency, then commits HI/LO.
- Raises a pipeline stall when a HI/LO instruction arrives while the unit is busy.

---
 rtl/md_sequencer_if.sv | 30 +++
 rtl/md_sequencer.sv | 127 ++++++++++++
 tb/tb_md_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/md_sequencer_if.sv
// E-stage <-> HI/LO multiply/divide sequencer handshake: decoded strobes, operands, results.
interface md_sequencer_if;
  logic        md_valid;
  logic        flush;
  logic        mult;
  logic        multu;
  logic        div;
  logic        divu;
  logic        mthi;
  logic        mtlo;
  logic        mfhi;
  logic        mflo;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall;

  modport master (
    output md_valid, flush, mult, multu, div, divu, mthi, mtlo, mfhi, mflo, op_a, op_b,
    input  hi, lo, rd_data, busy, stall
  );

  modport slave (
    input  md_valid, flush, mult, multu, div, divu, mthi, mtlo, mfhi, mflo, op_a, op_b,
    output hi, lo, rd_data, busy, stall
  );
endinterface

// File: rtl/md_sequencer.sv
// Fixed-latency HI/LO multiply/divide sequencer: computes the result at issue,
// holds it pending for MULT_CYCLES/DIV_CYCLES, then commits to HI/LO.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           rst_n,
  md_sequencer_if.slave md
);

  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;

  logic          acc;
  logic          any_strobe;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   abs_a;
  logic [31:0]   abs_b;
  logic [31:0]   mag_q;
  logic [31:0]   mag_r;
  logic [31:0]   div_q;
  logic [31:0]   div_r;

  assign acc        = md.md_valid & ~md.flush & (state == IDLE);
  assign any_strobe = md.mult | md.multu | md.div | md.divu |
                      md.mthi | md.mtlo | md.mfhi | md.mflo;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{md.op_a[31]}}, md.op_a} * {{32{md.op_b[31]}}, md.op_b};
  assign prod_u = {32'd0, md.op_a} * {32'd0, md.op_b};

  // Divide on magnitudes so 0x80000000 / -1 and truncation toward zero fall out naturally.
  always_comb begin
    abs_a = md.op_a;
    abs_b = md.op_b;
    mag_q = 32'd0;
    mag_r = 32'd0;
    div_q = 32'hFFFF_FFFF;
    div_r = md.op_a;
    if (md.div) begin
      abs_a = md.op_a[31] ? (~md.op_a + 32'd1) : md.op_a;
      abs_b = md.op_b[31] ? (~md.op_b + 32'd1) : md.op_b;
    end
    if (md.op_b != 32'd0) begin
      mag_q = abs_a / abs_b;
      mag_r = abs_a % abs_b;
      if (md.div) begin
        div_q = (md.op_a[31] ^ md.op_b[31]) ? (~mag_q + 32'd1) : mag_q;
        div_r = md.op_a[31] ? (~mag_r + 32'd1) : mag_r;
      end else begin
        div_q = mag_q;
        div_r = mag_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            if (md.mult) begin
              {pend_hi, pend_lo} <= prod_s;
              cnt                <= CW'(MULT_CYCLES);
              state              <= MUL;
            end else if (md.multu) begin
              {pend_hi, pend_lo} <= prod_u;
              cnt                <= CW'(MULT_CYCLES);
              state              <= MUL;
            end else if (md.div || md.divu) begin
              pend_hi <= div_r;
              pend_lo <= div_q;
              cnt     <= CW'(DIV_CYCLES);
              state   <= DIV;
            end else if (md.mthi) begin
              hi_q <= md.op_a;
            end else if (md.mtlo) begin
              lo_q <= md.op_a;
            end
          end
        end
        MUL, DIV: begin
          if (cnt == CW'(1)) begin
            hi_q  <= pend_hi;
            lo_q  <= pend_lo;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign md.hi      = hi_q;
  assign md.lo      = lo_q;
  assign md.busy    = (state != IDLE);
  assign md.stall   = md.md_valid & ~md.flush & (state != IDLE) & any_strobe;
  assign md.rd_data = md.mfhi ? hi_q : lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: latency, results, stalls, moves, flush and reset.
module tb_md_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  md_sequencer_if ifc ();

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic clr();
    ifc.md_valid = 1'b0; ifc.flush = 1'b0;
    ifc.mult = 1'b0; ifc.multu = 1'b0; ifc.div = 1'b0; ifc.divu = 1'b0;
    ifc.mthi = 1'b0; ifc.mtlo = 1'b0; ifc.mfhi = 1'b0; ifc.mflo = 1'b0;
    ifc.op_a = 32'd0; ifc.op_b = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b);
    clr();
    ifc.md_valid = 1'b1;
    ifc.op_a = a;
    ifc.op_b = b;
    case (sel)
      0: ifc.mult  = 1'b1;
      1: ifc.multu = 1'b1;
      2: ifc.div   = 1'b1;
      default: ifc.divu = 1'b1;
    endcase
    tick();
    clr();
  endtask

  task automatic test_reset();
    clr();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (ifc.hi !== 32'd0 || ifc.lo !== 32'd0 || ifc.busy !== 1'b0 || ifc.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset: hi=%h lo=%h busy=%b stall=%b required all zero", ifc.hi, ifc.lo, ifc.busy, ifc.stall);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Issue one mult/div op and check busy window, stable HI/LO, and commit.
  task automatic test_op(input string nm, input int sel, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] old_hi, old_lo;
    old_hi = ifc.hi;
    old_lo = ifc.lo;
    issue(sel, a, b);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (ifc.busy !== 1'b1 || ifc.hi !== old_hi || ifc.lo !== old_lo) begin
        errors++;
        $display("FAIL %s busy cyc %0d: busy=%b hi=%h lo=%h required busy=1 hi=%h lo=%h",
                 nm, i, ifc.busy, ifc.hi, ifc.lo, old_hi, old_lo);
      end
      tick();
    end
    checks++;
    if (ifc.busy !== 1'b0 || ifc.hi !== ehi || ifc.lo !== elo) begin
      errors++;
      $display("FAIL %s commit: busy=%b hi=%h lo=%h required busy=0 hi=%h lo=%h",
               nm, ifc.busy, ifc.hi, ifc.lo, ehi, elo);
    end
  endtask

  task automatic test_stall_mflo();
    issue(0, 32'd7, 32'd6);
    ifc.md_valid = 1'b1;
    ifc.mflo = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifc.stall !== 1'b1 || ifc.hi !== 32'd0 || ifc.lo !== 32'h0000_0000) begin
        errors++;
        $display("FAIL stall_mflo cyc %0d: stall=%b hi=%h lo=%h required stall=1 hi=0 lo=0",
                 i, ifc.stall, ifc.hi, ifc.lo);
      end
      tick();
    end
    checks++;
    if (ifc.stall !== 1'b0 || ifc.rd_data !== 32'h0000_002A || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_mflo release: stall=%b rd_data=%h busy=%b required stall=0 rd_data=0000002a busy=0",
               ifc.stall, ifc.rd_data, ifc.busy);
    end
    tick();
    clr();
  endtask

  task automatic test_stall_mthi();
    issue(2, 32'd100, 32'd7);
    ifc.md_valid = 1'b1;
    ifc.mthi = 1'b1;
    ifc.op_a = 32'h0000_DEAD;
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ifc.stall !== 1'b1 || ifc.hi !== 32'd0) begin
        errors++;
        $display("FAIL stall_mthi cyc %0d: stall=%b hi=%h required stall=1 hi=0", i, ifc.stall, ifc.hi);
      end
      tick();
    end
    checks++;
    if (ifc.stall !== 1'b0 || ifc.hi !== 32'd2 || ifc.lo !== 32'd14) begin
      errors++;
      $display("FAIL stall_mthi commit: stall=%b hi=%h lo=%h required stall=0 hi=2 lo=e",
               ifc.stall, ifc.hi, ifc.lo);
    end
    tick();
    clr();
    checks++;
    if (ifc.hi !== 32'h0000_DEAD || ifc.lo !== 32'd14 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_mthi override: hi=%h lo=%h busy=%b required hi=dead lo=e busy=0",
               ifc.hi, ifc.lo, ifc.busy);
    end
  endtask

  task automatic test_moves();
    clr();
    ifc.md_valid = 1'b1; ifc.mthi = 1'b1; ifc.op_a = 32'h1234_5678;
    #1;
    checks++;
    if (ifc.stall !== 1'b0) begin
      errors++;
      $display("FAIL moves mthi stall: stall=%b required 0", ifc.stall);
    end
    tick();
    checks++;
    if (ifc.hi !== 32'h1234_5678 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL moves mthi: hi=%h busy=%b required hi=12345678 busy=0", ifc.hi, ifc.busy);
    end
    clr();
    ifc.md_valid = 1'b1; ifc.mtlo = 1'b1; ifc.op_a = 32'h9ABC_DEF0;
    tick();
    checks++;
    if (ifc.lo !== 32'h9ABC_DEF0 || ifc.hi !== 32'h1234_5678 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL moves mtlo: hi=%h lo=%h busy=%b required hi=12345678 lo=9abcdef0 busy=0",
               ifc.hi, ifc.lo, ifc.busy);
    end
    clr();
    ifc.md_valid = 1'b1; ifc.mfhi = 1'b1;
    #1;
    checks++;
    if (ifc.rd_data !== 32'h1234_5678 || ifc.stall !== 1'b0) begin
      errors++;
      $display("FAIL moves mfhi: rd_data=%h stall=%b required 12345678 stall=0", ifc.rd_data, ifc.stall);
    end
    tick();
    clr();
  endtask

  task automatic test_flush_idle();
    clr();
    ifc.md_valid = 1'b1; ifc.flush = 1'b1; ifc.div = 1'b1;
    ifc.op_a = 32'd50; ifc.op_b = 32'd5;
    tick();
    clr();
    checks++;
    if (ifc.busy !== 1'b0 || ifc.hi !== 32'h1234_5678 || ifc.lo !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL flush_idle: busy=%b hi=%h lo=%h required busy=0 hi=12345678 lo=9abcdef0",
               ifc.busy, ifc.hi, ifc.lo);
    end
  endtask

  task automatic test_flush_busy();
    issue(0, 32'd3, 32'd4);
    ifc.md_valid = 1'b1; ifc.flush = 1'b1; ifc.mflo = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifc.stall !== 1'b0 || ifc.busy !== 1'b1) begin
        errors++;
        $display("FAIL flush_busy cyc %0d: stall=%b busy=%b required stall=0 busy=1", i, ifc.stall, ifc.busy);
      end
      tick();
    end
    clr();
    checks++;
    if (ifc.busy !== 1'b0 || ifc.hi !== 32'd0 || ifc.lo !== 32'd12) begin
      errors++;
      $display("FAIL flush_busy commit: busy=%b hi=%h lo=%h required busy=0 hi=0 lo=c",
               ifc.busy, ifc.hi, ifc.lo);
    end
  endtask

  task automatic test_reset_mid_div();
    issue(2, 32'd100, 32'd3);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (ifc.busy !== 1'b0 || ifc.hi !== 32'd0 || ifc.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_div: busy=%b hi=%h lo=%h required all zero", ifc.busy, ifc.hi, ifc.lo);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (ifc.busy !== 1'b0 || ifc.hi !== 32'd0 || ifc.lo !== 32'd0) begin
        errors++;
        $display("FAIL reset_mid_div late %0d: busy=%b hi=%h lo=%h required all zero",
                 i, ifc.busy, ifc.hi, ifc.lo);
      end
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_op("mult",   0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    test_op("multu",  1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    test_op("div",    2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_op("divu0",  3, 32'd7, 32'd0, 10, 32'h0000_0007, 32'hFFFF_FFFF);
    test_op("div_ov", 2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    test_op("b2b",    3, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    test_op("div0s",  2, 32'hFFFF_FFF0, 32'd0, 10, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    test_op("mult0",  0, 32'd0, 32'd0, 5, 32'd0, 32'd0);
    test_stall_mflo();
    test_op("clrlo",  0, 32'd0, 32'd0, 5, 32'd0, 32'd0);
    test_stall_mthi();
    test_moves();
    test_flush_idle();
    test_flush_busy();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
